// File: rtl/mult_arb_pkg.sv
// Shared constants and FSM encoding for mult_job_arbiter: peripheral register map,
// init command word and controller states.
package mult_arb_pkg;

  localparam logic [3:0] A_ADDR    = 4'h0;
  localparam logic [3:0] B_ADDR    = 4'h2;
  localparam logic [3:0] INIT_ADDR = 4'h4;
  localparam logic [3:0] LO_ADDR   = 4'h6;
  localparam logic [3:0] HI_ADDR   = 4'h8;
  localparam logic [3:0] STAT_ADDR = 4'hA;

  localparam logic [15:0] INIT_CMD = 16'h0001;

  typedef enum logic [2:0] {
    StIdle,
    StWrA,
    StWrB,
    StWrInit,
    StPoll,
    StRdLo,
    StRdHi,
    StResp
  } state_e;

endpackage

// File: rtl/mult_job_arbiter_if.sv
// Memory-mapped multiplier peripheral port, seen from the bus master (controller)
// and from the peripheral (slave).
interface mult_job_arbiter_if;

  logic [15:0] mul_d_in;
  logic [3:0]  mul_addr;
  logic        mul_cs;
  logic        mul_rd;
  logic        mul_wr;
  logic [15:0] mul_d_out;

  modport master (
    output mul_d_in, mul_addr, mul_cs, mul_rd, mul_wr,
    input  mul_d_out
  );

  modport slave (
    input  mul_d_in, mul_addr, mul_cs, mul_rd, mul_wr,
    output mul_d_out
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant_i and wraps
// modulo NREQ; returns the winner as one-hot and as an index.
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      // last_grant_i < NREQ and i <= NREQ, so one subtraction wraps the sum
      sum = {1'b0, last_grant_i} + (IdxW + 1)'(i);
      if (sum >= (IdxW + 1)'(NREQ)) begin
        sum = sum - (IdxW + 1)'(NREQ);
      end
      cand = sum[IdxW-1:0];
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/mult_job_arbiter.sv
// Shares one memory-mapped multiplier among NREQ requesters: round-robin grant, then
// write A/B/init, poll done, read product halves, ack. MULT_ARB_TIMEOUT_EN bounds polling.
module mult_job_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   a_in,
  input  logic [16*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          result,
  output logic                 err,
  output logic                 busy,
  mult_job_arbiter_if.master   bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [NREQ-1:0] grant_oh_q, grant_oh_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [15:0]     lo_q, lo_d;
  logic [31:0]     result_q, result_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IdxW-1:0] arb_idx;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned PcW = $clog2(POLL_MAX + 1);
  logic [PcW-1:0] poll_cnt_q, poll_cnt_d;
  logic           tmo_q, tmo_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_gnt),
    .idx_o        (arb_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IdxW'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      lo_q         <= '0;
      result_q     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      poll_cnt_q   <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      lo_q         <= lo_d;
      result_q     <= result_d;
`ifdef MULT_ARB_TIMEOUT_EN
      poll_cnt_q   <= poll_cnt_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    lo_d         = lo_q;
    result_d     = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
    poll_cnt_d   = poll_cnt_q;
    tmo_d        = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_gnt;
          a_d        = a_in[arb_idx*16 +: 16];
          b_d        = b_in[arb_idx*16 +: 16];
          phase_d    = 1'b0;
          state_d    = StWrA;
`ifdef MULT_ARB_TIMEOUT_EN
          poll_cnt_d = '0;
          tmo_d      = 1'b0;
`endif
        end
      end
      StWrA: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = StWrB;
      end
      StWrB: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = StWrInit;
      end
      StWrInit: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = StPoll;
      end
      StPoll: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bus.mul_d_out[0]) begin
            state_d = StRdLo;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (poll_cnt_q == PcW'(POLL_MAX - 1)) begin
            // Give up: ack with a zero product and flag the timeout
            state_d  = StResp;
            tmo_d    = 1'b1;
            result_d = '0;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
          end
`endif
        end
      end
      StRdLo: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          lo_d    = bus.mul_d_out;
          state_d = StRdHi;
        end
      end
      StRdHi: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          result_d = {bus.mul_d_out, lo_q};
          state_d  = StResp;
        end
      end
      StResp: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Writes strobe only in phase 0; reads hold addr/cs/rd through both phases
  always_comb begin
    bus.mul_d_in = '0;
    bus.mul_addr = '0;
    bus.mul_cs   = 1'b0;
    bus.mul_rd   = 1'b0;
    bus.mul_wr   = 1'b0;
    unique case (state_q)
      StWrA: if (!phase_q) begin
        bus.mul_addr = A_ADDR;
        bus.mul_d_in = a_q;
        bus.mul_cs   = 1'b1;
        bus.mul_wr   = 1'b1;
      end
      StWrB: if (!phase_q) begin
        bus.mul_addr = B_ADDR;
        bus.mul_d_in = b_q;
        bus.mul_cs   = 1'b1;
        bus.mul_wr   = 1'b1;
      end
      StWrInit: if (!phase_q) begin
        bus.mul_addr = INIT_ADDR;
        bus.mul_d_in = INIT_CMD;
        bus.mul_cs   = 1'b1;
        bus.mul_wr   = 1'b1;
      end
      StPoll: begin
        bus.mul_addr = STAT_ADDR;
        bus.mul_cs   = 1'b1;
        bus.mul_rd   = 1'b1;
      end
      StRdLo: begin
        bus.mul_addr = LO_ADDR;
        bus.mul_cs   = 1'b1;
        bus.mul_rd   = 1'b1;
      end
      StRdHi: begin
        bus.mul_addr = HI_ADDR;
        bus.mul_cs   = 1'b1;
        bus.mul_rd   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ack    = (state_q == StResp) ? grant_oh_q : '0;
    busy   = (state_q != StIdle);
    result = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
    err    = (state_q == StResp) && tmo_q;
`else
    err    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mult_job_arbiter.sv
// Random + directed bench for mult_job_arbiter against a job-level timeline model
// and a behavioural multiplier peripheral.
module tb_mult_job_arbiter;
  import mult_arb_pkg::*;

  localparam int unsigned NREQ     = 2;
  localparam int unsigned POLL_MAX = 4;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  a_in, b_in;
  logic [NREQ-1:0]     ack;
  logic [31:0]         result;
  logic                err, busy;

  mult_job_arbiter_if bus_if ();

  mult_job_arbiter #(
    .NREQ     (NREQ),
    .POLL_MAX (POLL_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .ack    (ack),
    .result (result),
    .err    (err),
    .busy   (busy),
    .bus    (bus_if.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int force_delay = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of not-done polls before done is reported
  function automatic int delay_of(input logic [15:0] a, input logic [15:0] b);
    if (force_delay >= 0) return force_delay;
    return int'((a ^ b) & 16'h3);
  endfunction

  // ---------------- behavioural multiplier peripheral ----------------
  logic [15:0] pa, pb;
  logic [31:0] pprod = '0;
  int          p_delay = 0;
  int          stat_cyc = 0;
  int          prod_rd_cyc = 0;

  always @(posedge clk) begin
    if (bus_if.mul_cs && bus_if.mul_wr) begin
      case (bus_if.mul_addr)
        A_ADDR: pa <= bus_if.mul_d_in;
        B_ADDR: pb <= bus_if.mul_d_in;
        INIT_ADDR: begin
          pprod    <= 32'(pa) * 32'(pb);
          p_delay  <= delay_of(pa, pb);
          stat_cyc <= 0;
        end
        default: ;
      endcase
    end
    if (bus_if.mul_cs && bus_if.mul_rd && bus_if.mul_addr == STAT_ADDR)
      stat_cyc <= stat_cyc + 1;
    if (bus_if.mul_cs && bus_if.mul_rd &&
        (bus_if.mul_addr == LO_ADDR || bus_if.mul_addr == HI_ADDR))
      prod_rd_cyc <= prod_rd_cyc + 1;
  end

  // A status read spans two cycles; poll n sees done once n >= p_delay
  always_comb begin
    bus_if.mul_d_out = '0;
    if (bus_if.mul_cs && bus_if.mul_rd) begin
      case (bus_if.mul_addr)
        STAT_ADDR: bus_if.mul_d_out = {15'b0, ((stat_cyc / 2) >= p_delay)};
        LO_ADDR:   bus_if.mul_d_out = pprod[15:0];
        HI_ADDR:   bus_if.mul_d_out = pprod[31:16];
        default:   bus_if.mul_d_out = '0;
      endcase
    end
  end

  // ---------------- job-level timeline model and per-cycle compare ----------------
  logic [19:0]     exp_wr[$];
  logic [19:0]     wr_log[$];
  logic [NREQ-1:0] last_ack = '0;

  initial begin
    bit              m_busy;
    int              m_left, m_grant, m_last, g, c, d;
    logic [31:0]     m_result, m_job_res;
    logic            m_job_err;
    logic [15:0]     a, b;
    logic [NREQ-1:0] exp_ack;
    bit              quiet;
    m_busy = 1'b0; m_left = 0; m_grant = 0; m_last = NREQ - 1;
    m_result = '0; m_job_res = '0; m_job_err = 1'b0;
    forever begin
      @(negedge clk);
      last_ack = ack;
      if (!rst) begin
        check("rst_outs", {ack, result, err, busy}, '0);
        check("rst_bus", {bus_if.mul_d_in, bus_if.mul_addr, bus_if.mul_cs,
                          bus_if.mul_rd, bus_if.mul_wr}, '0);
        m_busy = 1'b0; m_last = NREQ - 1; m_result = '0;
        exp_wr.delete();
      end else begin
        exp_ack = '0;
        quiet   = !m_busy;
        if (m_busy && m_left == 0) begin
          exp_ack[m_grant] = 1'b1;
          quiet = 1'b1;
        end
        check("ack", ack, exp_ack);
        check("busy", busy, m_busy);
        check("result", result, (exp_ack != 0) ? m_job_res : m_result);
        check("err", err, (exp_ack != 0) ? m_job_err : 1'b0);
        if (quiet)
          check("bus_quiet", {bus_if.mul_d_in, bus_if.mul_addr, bus_if.mul_cs,
                              bus_if.mul_rd, bus_if.mul_wr}, '0);
        if (bus_if.mul_wr) begin
          wr_log.push_back({bus_if.mul_addr, bus_if.mul_d_in});
          if (exp_wr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wr_extra: write %0h@%0h with none expected at %0t",
                     bus_if.mul_d_in, bus_if.mul_addr, $time);
          end else begin
            check("wr_seq", {bus_if.mul_addr, bus_if.mul_d_in}, exp_wr.pop_front());
          end
        end
        if (exp_ack != 0) check("wr_all_done", exp_wr.size(), 0);
        // advance to next cycle
        if (!m_busy) begin
          g = -1;
          for (int i = 1; i <= NREQ; i++) begin
            c = (m_last + i) % NREQ;
            if (g < 0 && req[c]) g = c;
          end
          if (g >= 0) begin
            a = a_in[16*g +: 16];
            b = b_in[16*g +: 16];
            d = delay_of(a, b);
            if (TMO && d >= int'(POLL_MAX)) begin
              m_left = 6 + 2 * POLL_MAX; m_job_res = '0; m_job_err = 1'b1;
            end else begin
              m_left = 10 + 2 * (d + 1); m_job_res = 32'(a) * 32'(b); m_job_err = 1'b0;
            end
            exp_wr.push_back({A_ADDR, a});
            exp_wr.push_back({B_ADDR, b});
            exp_wr.push_back({INIT_ADDR, INIT_CMD});
            m_busy = 1'b1; m_grant = g;
          end
        end else if (m_left == 0) begin
          m_busy = 1'b0; m_last = m_grant; m_result = m_job_res;
        end else begin
          m_left--;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 1 is the cycle in which req was driven
  task automatic wait_ack(input int idx, input int maxc, output int n);
    n = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (ack[idx]) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: no ack[%0d] within %0d cycles", idx, maxc);
    end
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n, pr0;
    int order[$];
    int exp_rr[4] = '{0, 1, 0, 1};
    rst = 1'b0; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_busy", busy, 1'b0);
    step(); rst = 1'b1;
    step(); step();

    // 5 * 2, done on first poll
    force_delay = 0; wr_log.delete();
    a_in[15:0] = 16'd5; b_in[15:0] = 16'd2; req = 2'b01;
    wait_ack(0, 60, n);
    check("lat_first_poll", n, 14);
    check("res_5x2", result, 32'd10);
    check("polls_1", stat_cyc, 2);
    check("wr_log_n", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("wr_a", wr_log[0], 20'h0_0005);
      check("wr_b", wr_log[1], 20'h2_0002);
      check("wr_init", wr_log[2], 20'h4_0001);
    end
    step(); req = '0; step();

    // largest operands
    a_in[15:0] = 16'hFFFF; b_in[15:0] = 16'hFFFF; req = 2'b01;
    wait_ack(0, 60, n);
    check("lat_ffff", n, 14);
    check("res_ffff", result, 32'hFFFE0001);
    check("err_ffff", err, 1'b0);
    step(); req = '0; step();

    // simultaneous requests after reset: 0 first, then alternate
    rst = 1'b0; step(); rst = 1'b1; step();
    a_in = {16'd6, 16'd3}; b_in = {16'd7, 16'd4}; req = 2'b11;
    order.delete();
    for (int k = 0; k < 200 && order.size() < 4; k++) begin
      @(negedge clk);
      if (ack != 0) order.push_back(ack[1] ? 1 : 0);
    end
    check("rr_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) check("rr_order", order[k], exp_rr[k]);
    check("rr_last_res", result, 32'd42);
    step(); req = '0; step();

    // done after three not-done polls
    force_delay = 3;
    a_in[15:0] = 16'd9; b_in[15:0] = 16'd9; req = 2'b01;
    wait_ack(0, 80, n);
    check("lat_4_polls", n, 20);
    check("polls_4", stat_cyc, 8);
    check("res_9x9", result, 32'd81);
    step(); req = '0; step();

`ifdef MULT_ARB_TIMEOUT_EN
    // done never set: abort after POLL_MAX polls
    force_delay = 1000; pr0 = prod_rd_cyc;
    a_in[15:0] = 16'd2; b_in[15:0] = 16'd3; req = 2'b01;
    wait_ack(0, 80, n);
    check("lat_timeout", n, 16);
    check("tmo_err", err, 1'b1);
    check("tmo_result", result, 32'h0);
    check("tmo_polls", stat_cyc, 2 * POLL_MAX);
    check("tmo_no_prod_rd", prod_rd_cyc - pr0, 0);
    step(); req = '0; force_delay = 0; step();
`endif

    // asynchronous reset during WR_B, then restart with fresh operands
    force_delay = 0;
    a_in[15:0] = 16'd7; b_in[15:0] = 16'd9; req = 2'b01;
    repeat (3) step();
    check("in_wr_b", {bus_if.mul_addr, bus_if.mul_d_in, bus_if.mul_wr}, {4'h2, 16'd9, 1'b1});
    rst = 1'b0;
    #2;
    check("rst_mid_bus", {bus_if.mul_cs, bus_if.mul_wr, bus_if.mul_addr, bus_if.mul_d_in}, '0);
    check("rst_mid_busy", {busy, ack}, '0);
    a_in[15:0] = 16'd11; b_in[15:0] = 16'd13;
    step(); rst = 1'b1; wr_log.delete();
    wait_ack(0, 60, n);
    check("lat_restart", n, 14);
    check("res_restart", result, 32'd143);
    if (wr_log.size() > 0) check("wr_a_restart", wr_log[0], 20'h0_000B);
    step(); req = '0; step();

    // randomized traffic
    force_delay = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && last_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            a_in[16*i +: 16] = rnd_op();
            b_in[16*i +: 16] = rnd_op();
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          a_in[16*i +: 16] = rnd_op();
        end
      end
    end
    step(); req = '0;
    repeat (80) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
